countdown_timer: RTL and testbench

Presettable minutes:seconds countdown timer, the count-down counterpart of the stopwatch. The operator loads a preset and uses start/stop/reset controls. The block decrements to 00:00, then flags expiry. Output encoding matches the stopwatch (8-bit minutes, 6-bit seconds, 2-bit status), so both blocks share one display path.

---
 rtl/countdown_timer_if.sv | 25 ++
 rtl/countdown_timer.sv | 147 ++++++++++++++
 tb/tb_countdown_timer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control/display bundle for the minutes:seconds countdown timer.
// master: operator side (drives controls, reads display)
// slave:  timer side (reads controls, drives display)
interface countdown_timer_if;
    logic       load;
    logic [7:0] load_min;
    logic [5:0] load_sec;
    logic       start;
    logic       stop;
    logic       reset;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;
    logic       done;

    modport master (
        output load, load_min, load_sec, start, stop, reset,
        input  minutes, seconds, status, done
    );

    modport slave (
        input  load, load_min, load_sec, start, stop, reset,
        output minutes, seconds, status, done
    );
endinterface

// File: rtl/countdown_timer.sv
// Presettable minutes:seconds countdown timer. Shares the stopwatch output
// encoding (8-bit minutes, 6-bit seconds, 2-bit status) so both can drive one
// display path. Control priority on every edge: reset > load > stop > start.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: on expiry the count reloads
// from the last loaded preset and keeps running (unless that preset is 00:00).
module countdown_timer #(
    parameter int MAX_MIN  = 99,
    parameter int TICK_DIV = 1
) (
    input logic               clk,
    input logic               rst_n,
    countdown_timer_if.slave  bus
);

    // A one-bit prescaler is kept for TICK_DIV == 1; it simply stays at zero.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_EXPIRED = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            done_q, done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [7:0]      rel_min_q, rel_min_d;
    logic [5:0]      rel_sec_q, rel_sec_d;
`endif

    logic tick;
    logic count_nz;
    logic last_sec;

    function automatic logic [7:0] sat_min(input logic [7:0] v);
        return (v > 8'(MAX_MIN)) ? 8'(MAX_MIN) : v;
    endfunction

    function automatic logic [5:0] sat_sec(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

    assign tick     = (presc_q == PW'(TICK_DIV - 1));
    assign count_nz = (min_q != 8'd0) || (sec_q != 6'd0);
    // The decrement about to happen is the one that lands on 00:00.
    assign last_sec = (min_q == 8'd0) && (sec_q <= 6'd1);

    // Next-state and next-count logic, priority reset > load > stop > run/start.
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        sec_d     = sec_q;
        presc_d   = presc_q;
        done_d    = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        rel_min_d = rel_min_q;
        rel_sec_d = rel_sec_q;
`endif
        if (bus.reset) begin
            state_d   = ST_IDLE;
            min_d     = 8'd0;
            sec_d     = 6'd0;
            presc_d   = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rel_min_d = 8'd0;
            rel_sec_d = 6'd0;
`endif
        end else if (bus.load && (state_q != ST_RUNNING)) begin
            state_d   = ST_IDLE;
            min_d     = sat_min(bus.load_min);
            sec_d     = sat_sec(bus.load_sec);
            presc_d   = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rel_min_d = sat_min(bus.load_min);
            rel_sec_d = sat_sec(bus.load_sec);
`endif
        end else if (bus.stop) begin
            // Pausing freezes the prescaler so a resume keeps the partial second.
            if (state_q == ST_RUNNING) begin
                state_d = ST_PAUSED;
            end
        end else if (state_q == ST_RUNNING) begin
            if (tick) begin
                presc_d = '0;
                if (sec_q != 6'd0) begin
                    sec_d = sec_q - 6'd1;
                end else begin
                    min_d = min_q - 8'd1;
                    sec_d = 6'd59;
                end
                if (last_sec) begin
                    done_d  = 1'b1;
                    state_d = ST_EXPIRED;
                    min_d   = 8'd0;
                    sec_d   = 6'd0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if ((rel_min_q != 8'd0) || (rel_sec_q != 6'd0)) begin
                        state_d = ST_RUNNING;
                        min_d   = rel_min_q;
                        sec_d   = rel_sec_q;
                    end
`endif
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else if (bus.start && count_nz &&
                     ((state_q == ST_IDLE) || (state_q == ST_PAUSED))) begin
            state_d = ST_RUNNING;
        end
    end

    // State, count, prescaler and done registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            min_q     <= 8'd0;
            sec_q     <= 6'd0;
            presc_q   <= '0;
            done_q    <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rel_min_q <= 8'd0;
            rel_sec_q <= 6'd0;
`endif
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rel_min_q <= rel_min_d;
            rel_sec_q <= rel_sec_d;
`endif
        end
    end

    assign bus.minutes = min_q;
    assign bus.seconds = sec_q;
    assign bus.status  = state_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: two instances (TICK_DIV 1 and 4) share
// one stimulus stream; a reference model working in total remaining seconds
// pushes the expected display per edge, and a monitor pops and compares.
module tb_countdown_timer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       t_load = 1'b0;
    logic [7:0] t_lmin = 8'd0;
    logic [5:0] t_lsec = 6'd0;
    logic       t_start = 1'b0;
    logic       t_stop = 1'b0;
    logic       t_reset = 1'b0;

    countdown_timer_if ifa ();
    countdown_timer_if ifb ();

    assign ifa.load = t_load;   assign ifb.load = t_load;
    assign ifa.load_min = t_lmin; assign ifb.load_min = t_lmin;
    assign ifa.load_sec = t_lsec; assign ifb.load_sec = t_lsec;
    assign ifa.start = t_start; assign ifb.start = t_start;
    assign ifa.stop = t_stop;   assign ifb.stop = t_stop;
    assign ifa.reset = t_reset; assign ifb.reset = t_reset;

    countdown_timer #(.MAX_MIN(99), .TICK_DIV(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    countdown_timer #(.MAX_MIN(99), .TICK_DIV(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: remaining time as total seconds, status as 0..3.
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_EXP = 3;
    int m_td[2] = '{1, 4};
    int m_state[2];
    int m_rem[2];
    int m_run_cnt[2];
    int m_rel[2];
    bit m_done[2];

    typedef struct packed {
        logic [16:0] a;
        logic [16:0] b;
    } exp_t;
    exp_t sb_q[$];

    function automatic logic [16:0] exp_of(input int i);
        return {8'(m_rem[i] / 60), 6'(m_rem[i] % 60), 2'(m_state[i]), m_done[i]};
    endfunction

    task automatic model_clear(input int i);
        m_state[i] = S_IDLE; m_rem[i] = 0; m_run_cnt[i] = 0; m_rel[i] = 0; m_done[i] = 0;
    endtask

    task automatic model_step(input int i);
        int m, s;
        m_done[i] = 0;
        if (!rst_n || t_reset) begin
            model_clear(i);
        end else if (t_load && m_state[i] != S_RUN) begin
            m = (int'(t_lmin) > 99) ? 99 : int'(t_lmin);
            s = (int'(t_lsec) > 59) ? 59 : int'(t_lsec);
            m_rem[i] = m * 60 + s;
            m_rel[i] = m_rem[i];
            m_state[i] = S_IDLE;
            m_run_cnt[i] = 0;
        end else if (t_stop) begin
            if (m_state[i] == S_RUN) m_state[i] = S_PAUSE;
        end else if (m_state[i] == S_RUN) begin
            m_run_cnt[i]++;
            if (m_run_cnt[i] == m_td[i]) begin
                m_run_cnt[i] = 0;
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_done[i] = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    if (m_rel[i] != 0) m_rem[i] = m_rel[i];
                    else m_state[i] = S_EXP;
`else
                    m_state[i] = S_EXP;
`endif
                end
            end
        end else if (t_start && m_rem[i] != 0 && (m_state[i] == S_IDLE || m_state[i] == S_PAUSE)) begin
            m_state[i] = S_RUN;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.a = exp_of(0);
        e.b = exp_of(1);
        sb_q.push_back(e);
    endtask

    // One clock of stimulus: drive at the falling edge, predict the next rising edge.
    task automatic cyc(input bit ld, input int lm, input int ls, input bit st, input bit sp, input bit rs);
        @(negedge clk);
        t_load = ld; t_lmin = 8'(lm); t_lsec = 6'(ls);
        t_start = st; t_stop = sp; t_reset = rs;
        model_step(0);
        model_step(1);
        push_expected();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_load(input int lm, input int ls);
        cyc(1, lm, ls, 0, 0, 0);
    endtask

    // Pull rst_n low between edges and check the outputs clear without a clock.
    task automatic async_abort();
        @(negedge clk);
        t_load = 0; t_start = 0; t_stop = 0; t_reset = 0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ifa.minutes, ifa.seconds, ifa.status, ifa.done} != 17'd0 ||
            {ifb.minutes, ifb.seconds, ifb.status, ifb.done} != 17'd0) begin
            n_fail++;
            $display("FAIL async_reset: a=%0d:%0d st=%0d d=%0d b=%0d:%0d st=%0d d=%0d, required 0:0 st=0 d=0",
                     ifa.minutes, ifa.seconds, ifa.status, ifa.done,
                     ifb.minutes, ifb.seconds, ifb.status, ifb.done);
        end
        model_step(0);
        model_step(1);
        push_expected();
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_step(0);
        model_step(1);
        push_expected();
    endtask

    // Monitor: the display is presented every edge; compare each against the scoreboard.
    initial begin
        exp_t e;
        logic [16:0] ga, gb;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                ga = {ifa.minutes, ifa.seconds, ifa.status, ifa.done};
                gb = {ifb.minutes, ifb.seconds, ifb.status, ifb.done};
                n_checks++;
                if (ga !== e.a) begin
                    n_fail++;
                    $display("FAIL div1 t=%0t: got %0d:%0d st=%0d d=%0d, required %0d:%0d st=%0d d=%0d", $time,
                             ga[16:9], ga[8:3], ga[2:1], ga[0], e.a[16:9], e.a[8:3], e.a[2:1], e.a[0]);
                end
                n_checks++;
                if (gb !== e.b) begin
                    n_fail++;
                    $display("FAIL div4 t=%0t: got %0d:%0d st=%0d d=%0d, required %0d:%0d st=%0d d=%0d", $time,
                             gb[16:9], gb[8:3], gb[2:1], gb[0], e.b[16:9], e.b[8:3], e.b[2:1], e.b[0]);
                end
            end
        end
    end

    initial begin
        int r;
        model_clear(0);
        model_clear(1);
        // Power-on reset held across a few edges.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_step(0); model_step(1); push_expected();

        // Load 1:02, run through expiry, then a start in EXPIRED.
        do_load(1, 2);
        cyc(0, 0, 0, 1, 0, 0);
        idle(70);
        cyc(0, 0, 0, 1, 0, 0);
        idle(3);

        // Abort mid-count with rst_n.
        cyc(0, 0, 0, 0, 0, 1);
        do_load(0, 40);
        cyc(0, 0, 0, 1, 0, 0);
        idle(10);
        async_abort();

        // Pause and resume.
        do_load(0, 10);
        cyc(0, 0, 0, 1, 0, 0);
        idle(3);
        cyc(0, 0, 0, 0, 1, 0);
        idle(20);
        cyc(0, 0, 0, 1, 0, 0);
        idle(5);

        // Saturation, load while running, start+stop, reset+load.
        cyc(0, 0, 0, 0, 0, 1);
        do_load(150, 63);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2);
        cyc(1, 0, 5, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 1, 1, 0);
        idle(2);
        cyc(1, 3, 3, 0, 0, 1);
        do_load(0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        idle(2);

        // Prescaler hold across a pause (TICK_DIV=4 instance stops at prescaler 2).
        do_load(0, 20);
        cyc(0, 0, 0, 1, 0, 0);
        idle(6);
        cyc(0, 0, 0, 0, 1, 0);
        idle(4);
        cyc(0, 0, 0, 1, 0, 0);
        idle(6);

        // Short preset to exercise expiry (and reload when enabled).
        do_load(0, 3);
        cyc(0, 0, 0, 1, 0, 0);
        idle(30);

        // Randomized control traffic.
        for (int k = 0; k < 2500; k++) begin
            r = $urandom_range(0, 199);
            if (r == 0) async_abort();
            else if (r < 3) cyc(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1);
            else if (r < 12) cyc(1, ($urandom_range(0, 9) == 0) ? $urandom_range(100, 255) : $urandom_range(0, 1),
                                 $urandom_range(0, 63), $urandom_range(0, 1), $urandom_range(0, 1), 0);
            else if (r < 40) cyc(0, 0, 0, 1, ($urandom_range(0, 5) == 0), 0);
            else if (r < 46) cyc(0, 0, 0, 0, 1, 0);
            else cyc(0, 0, 0, 0, 0, 0);
        end

        // Drain the scoreboard.
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
